spi_bus_arbiter: RTL

//  Shares one SPI_mstr16 engine between NUM_REQ requesters (inertial interface, A2D monitor, ...).

---
 rtl/spi_arb_pkg.sv | 25 ++
 rtl/spi_bus_arbiter_rr.sv | 38 +++
 rtl/spi_bus_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter and the requesters that sit on it.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      GAP   = 2'd3
   } arb_state_e;

   localparam int unsigned DEF_NUM_REQ     = 2;
   localparam int unsigned DEF_GAP_CYC     = 4;
   localparam int unsigned DEF_TIMEOUT_CYC = 4096;

   localparam int unsigned CMD_W = 16;
   localparam int unsigned RD_W  = 8;

   // Command words shared with the requester FSMs (bit 15 set = register read)
   localparam logic [CMD_W-1:0] CMD_RD_FLAG      = 16'h8000;
   localparam logic [CMD_W-1:0] CMD_INERT_WHOAMI = 16'h8F00;
   localparam logic [CMD_W-1:0] CMD_INERT_INTCFG = 16'h0D02;
   localparam logic [CMD_W-1:0] CMD_INERT_PITCH  = 16'hA200;
   localparam logic [CMD_W-1:0] CMD_INERT_YAW    = 16'hA600;

endpackage

// File: rtl/spi_bus_arbiter_rr.sv
// Combinational round-robin picker: first pending requester at or after the pointer.
module rr_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned N  = DEF_NUM_REQ,
   parameter int unsigned PW = $clog2(DEF_NUM_REQ)
) (
   input  logic [N-1:0]  pending,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          valid
);

   localparam int unsigned SW = PW + 1;

   logic [SW-1:0] sum;
   logic [PW-1:0] idx;
   logic          found;

   // Walk the requesters starting at ptr, wrapping modulo N
   always_comb begin
      grant = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + SW'(k);
         if (sum >= SW'(N)) sum = sum - SW'(N);
         idx = sum[PW-1:0];
         if (!found && pending[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      valid = found;
   end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI_mstr16 between NUM_REQ requesters: captures strobes, grants round-robin,
// returns done/rd_data to the owner and steers the master's SS_n to the owner's slave.
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
   parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_wrt,
   input  logic [NUM_REQ-1:0][CMD_W-1:0]   req_cmd,
   output logic [NUM_REQ-1:0]              req_done,
   output logic [RD_W-1:0]                 req_rd_data,
   output logic [NUM_REQ-1:0]              req_busy,
   output logic                            mstr_wrt,
   output logic [CMD_W-1:0]                mstr_cmd,
   input  logic                            mstr_done,
   input  logic [RD_W-1:0]                 mstr_rd_data,
   input  logic                            mstr_SS_n,
   output logic [NUM_REQ-1:0]              SS_n_out,
   output logic [NUM_REQ-1:0]              err_ovf,
   output logic                            err_timeout
);

   localparam int unsigned PW = $clog2(NUM_REQ);
   localparam int unsigned GW = $clog2(GAP_CYC + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   arb_state_e                      state;
   logic [PW-1:0]                   owner;
   logic [PW-1:0]                   rr_ptr;
   logic [PW-1:0]                   grant_idx;
   logic [NUM_REQ-1:0]              pending;
   logic [NUM_REQ-1:0]              grant;
   logic                            grant_vld;
   logic [NUM_REQ-1:0][CMD_W-1:0]   cmd_q;
   logic [GW-1:0]                   gap_cnt;
   logic [TW-1:0]                   to_cnt;

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr (
      .pending (pending),
      .ptr     (rr_ptr),
      .grant   (grant),
      .valid   (grant_vld)
   );

   always_comb begin
      grant_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) grant_idx = PW'(i);
      end
   end

   // Owner stops counting as busy once its transaction reaches GAP
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_busy[i] = pending[i] | ((owner == PW'(i)) && ((state == ISSUE) || (state == BUSY)));
         SS_n_out[i] = ((owner == PW'(i)) && (state != IDLE)) ? mstr_SS_n : 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= '0;
         rr_ptr      <= '0;
         pending     <= '0;
         cmd_q       <= '0;
         mstr_wrt    <= 1'b0;
         mstr_cmd    <= '0;
         req_done    <= '0;
         req_rd_data <= '0;
         err_ovf     <= '0;
         err_timeout <= 1'b0;
         gap_cnt     <= '0;
         to_cnt      <= '0;
      end else begin
         mstr_wrt <= 1'b0;
         req_done <= '0;

         case (state)
            IDLE: begin
               if (grant_vld) begin
                  owner    <= grant_idx;
                  mstr_wrt <= 1'b1;
                  mstr_cmd <= cmd_q[grant_idx];
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               pending[owner] <= 1'b0;
               to_cnt         <= '0;
               state          <= BUSY;
            end
            BUSY: begin
               if (mstr_done) begin
                  req_rd_data     <= mstr_rd_data;
                  req_done[owner] <= 1'b1;
                  gap_cnt         <= '0;
                  state           <= GAP;
               end else begin
                  // Timeout is only flagged; the transaction keeps waiting for done
                  if (to_cnt == TW'(TIMEOUT_CYC - 1)) err_timeout <= 1'b1;
                  if (to_cnt != TW'(TIMEOUT_CYC)) to_cnt <= to_cnt + TW'(1);
               end
            end
            GAP: begin
               if (gap_cnt == GW'(GAP_CYC - 1)) begin
                  rr_ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
                  state  <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase

         // Strobe capture; a strobe while busy is dropped and flagged
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_wrt[i]) begin
               if (req_busy[i]) begin
                  err_ovf[i] <= 1'b1;
               end else begin
                  pending[i] <= 1'b1;
                  cmd_q[i]   <= req_cmd[i];
               end
            end
         end
      end
   end

endmodule
